// File: rtl/foo_pipe_arbiter_pkg.sv
// Shared definitions for the foo pipelined arbiter.
//   PIPE_LATENCY : cycles from an accepted operand to its response
//   stage_t      : per-stage pipeline record {valid, id, data}, sized for the
//                  largest supported configuration; narrower instances
//                  zero-extend into it and slice back out at the output.
package foo_pipe_arbiter_pkg;

    localparam int PIPE_LATENCY = 3;
    localparam int STAGE_ID_W   = 4;    // enough for 16 requesters
    localparam int STAGE_DATA_W = 64;

    typedef struct packed {
        logic                    valid;
        logic [STAGE_ID_W-1:0]   id;
        logic [STAGE_DATA_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/foo_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index; search runs ptr, ptr+1, ... mod NUM_REQ
//   grant : one-hot grant to the first requester found, or zero
module foo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/foo_pipe_arbiter.sv
// Round-robin arbiter feeding a two-stage increment pipeline plus an output
// register; each operand returns as operand + 3 tagged with its requester id.
//   clk, rst            : clock, async active-high reset
//   req_valid/req_data  : per-requester operand handshake (no queueing)
//   req_ready           : one-hot-or-zero grant
//   stall               : freezes every pipeline register and blocks issue
//   resp_valid/id/data  : registered result, no back-pressure
//   in_flight           : number of valid ops in stage 0 and stage 1
module foo_pipe_arbiter
    import foo_pipe_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic [1:0]                in_flight
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W > STAGE_ID_W || DATA_W > STAGE_DATA_W) begin : g_bad_cfg
        $error("foo_pipe_arbiter: unsupported NUM_REQ/ID_W/DATA_W");
    end

    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    grant;
    logic                  fire;
    logic [ID_W-1:0]       gnt_id;
    logic [DATA_W-1:0]     gnt_data;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    stage_t                s0_q, s0_d;
    stage_t                s1_q, s1_d;
    stage_t                out_q, out_d;
    logic [STAGE_DATA_W-1:0] s0_res, s1_res;
    logic                  pad_unused;

    // Reset is folded in so req_ready reads zero for the whole reset window.
    assign arb_req = (stall || rst) ? '0 : req_valid;

    foo_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_ready = grant;
    // grant is a subset of req_valid, so any grant bit is an accepted transfer.
    assign fire      = |grant;

    always_comb begin
        gnt_id   = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id   = ID_W'(i);
                gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // Arithmetic runs at the full record width; carries past DATA_W land in
    // padding bits that never reach resp_data, so the low bits stay modular.
    assign s0_res = s0_q.data + STAGE_DATA_W'(1);
    assign s1_res = {s1_q.data[STAGE_DATA_W-1:1] + (STAGE_DATA_W-1)'(1), s1_q.data[0]};

    always_comb begin
        s0_d  = s0_q;
        s1_d  = s1_q;
        out_d = out_q;
        if (!stall) begin
            s0_d.valid  = fire;             // no transfer -> bubble
            s0_d.id     = STAGE_ID_W'(gnt_id);
            s0_d.data   = STAGE_DATA_W'(gnt_data);
            s1_d.valid  = s0_q.valid;
            s1_d.id     = s0_q.id;
            s1_d.data   = s0_res;
            out_d.valid = s1_q.valid;
            out_d.id    = s1_q.id;
            out_d.data  = s1_res;
        end
    end

    // Only valids, pointer and the output record are reset; stage payloads
    // are don't-care while their valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            s0_q.valid <= 1'b0;
            s1_q.valid <= 1'b0;
            out_q      <= '0;
        end else begin
            ptr_q <= ptr_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            out_q <= out_d;
        end
    end

    assign resp_valid = out_q.valid;
    assign resp_id    = out_q.id[ID_W-1:0];
    assign resp_data  = out_q.data[DATA_W-1:0];
    assign in_flight  = 2'(s0_q.valid) + 2'(s1_q.valid);

    // Padding bits of the output record are never driven out.
    assign pad_unused = ^{out_q.id, out_q.data};

endmodule

// File: tb/tb_foo_pipe_arbiter.sv
module tb_foo_pipe_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              resp_valid;
    logic [IW-1:0]     resp_id;
    logic [DW-1:0]     resp_data;
    logic [1:0]        in_flight;

    foo_pipe_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .in_flight  (in_flight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          acc_tick;
        int          acc_stall;
    } exp_t;
    typedef logic [DW-1:0] opq_t[$];

    exp_t sb[$];
    opq_t rq[NR];
    int   gnt_log[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_ptr = 0;
    logic m_s0 = 1'b0, m_s1 = 1'b0, m_out = 1'b0;
    logic stall_now = 1'b0;
    int   tick_no = 0;
    int   stall_ticks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive from requester queues, check against the model, then
    // advance the model across the coming posedge.
    task automatic tick();
        logic [NR-1:0] v;
        logic [NR-1:0] eg;
        int            g;
        int            j;
        exp_t          e;
        @(negedge clk);
        tick_no++;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                v[i] = 1'b1;
                req_data[i*DW +: DW] = rq[i][0];
            end
        end
        req_valid = v;
        stall     = stall_now;
        #1;
        eg = '0;
        g  = -1;
        if (!stall_now) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (g < 0 && v[j]) begin
                    g     = j;
                    eg[j] = 1'b1;
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("resp_valid", 64'(resp_valid), 64'(m_out));
        chk("in_flight", 64'(in_flight), 64'(m_s0) + 64'(m_s1));
        if (resp_valid && stall_now && sb.size() > 0) begin
            chk("resp_hold_id", 64'(resp_id), 64'(sb[0].id));
            chk("resp_hold_data", 64'(resp_data), 64'(sb[0].data));
        end
        if (resp_valid && !stall_now) begin
            if (sb.size() == 0) begin
                chk("resp_spurious", 64'(resp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_data", 64'(resp_data), 64'(e.data));
                chk("latency", 64'(tick_no - e.acc_tick), 64'(3 + stall_ticks - e.acc_stall));
            end
        end
        if (stall_now) begin
            stall_ticks++;
        end else begin
            m_out = m_s1;
            m_s1  = m_s0;
            m_s0  = (g >= 0);
            if (g >= 0) begin
                e.id        = g;
                e.data      = rq[g][0] + 32'd3;
                e.acc_tick  = tick_no;
                e.acc_stall = stall_ticks;
                sb.push_back(e);
                void'(rq[g].pop_front());
                gnt_log.push_back(g);
                m_ptr = (g + 1) % NR;
            end
        end
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        req_valid = '1;
        stall     = 1'b0;
        stall_now = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_id", 64'(resp_id), 64'(0));
        chk("rst_resp_data", 64'(resp_data), 64'(0));
        chk("rst_in_flight", 64'(in_flight), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        sb.delete();
        foreach (rq[i]) rq[i].delete();
        m_s0 = 1'b0; m_s1 = 1'b0; m_out = 1'b0; m_ptr = 0;
        repeat (cyc) @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic drain();
        int n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 60) begin
            tick();
            n++;
            busy = (sb.size() != 0) || m_s0 || m_s1 || m_out;
            foreach (rq[i]) if (rq[i].size() != 0) busy = 1'b1;
        end
        chk("drain_left", 64'(sb.size()), 64'(0));
        tick();
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_cnt"}, 64'(gnt_log.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < gnt_log.size(); k++)
            chk(tag, 64'(gnt_log[k]), 64'(exp[k]));
    endtask

    initial begin
        do_reset(2);

        // single request from requester 2
        rq[2].push_back(32'h0000_0010);
        drain();

        // all four requesters held valid
        do_reset(1);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) rq[i].push_back(32'h100 * i + k);
        gnt_log.delete();
        repeat (8) tick();
        chk_order("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});
        drain();

        // wrap-around
        rq[0].push_back(32'hFFFF_FFFD);
        rq[1].push_back(32'hFFFF_FFFF);
        drain();

        // stall with two ops in flight and a response showing
        do_reset(1);
        rq[0].push_back(32'hA0);
        rq[1].push_back(32'hB0);
        rq[2].push_back(32'hC0);
        repeat (3) tick();
        rq[3].push_back(32'hD0);
        stall_now = 1'b1;
        repeat (5) tick();
        stall_now = 1'b0;
        drain();

        // reset with work in flight
        rq[0].push_back(32'h11);
        rq[1].push_back(32'h22);
        rq[2].push_back(32'h33);
        repeat (3) tick();
        @(posedge clk);
        #1;
        chk("pre_rst_in_flight", 64'(in_flight), 64'(2));
        chk("pre_rst_resp_valid", 64'(resp_valid), 64'(1));
        do_reset(2);
        repeat (6) tick();

        // pointer fairness: walk p to 2, then only requesters 1 and 3
        rq[0].push_back(32'h5);
        rq[1].push_back(32'h6);
        gnt_log.delete();
        repeat (2) tick();
        chk_order("ptr_after_rst", '{0, 1});
        gnt_log.delete();
        rq[1].push_back(32'h61); rq[1].push_back(32'h62);
        rq[3].push_back(32'h31); rq[3].push_back(32'h32);
        repeat (4) tick();
        chk_order("fair_order", '{3, 1, 3, 1});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
